// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, register map and fill FSM encoding for the
// 160x120 RGB332 framebuffer and the blocks that write into it.
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;

    localparam logic [2:0] REG_X0    = 3'd0;
    localparam logic [2:0] REG_Y0    = 3'd1;
    localparam logic [2:0] REG_W     = 3'd2;
    localparam logic [2:0] REG_H     = 3'd3;
    localparam logic [2:0] REG_COLOR = 3'd4;
    localparam logic [2:0] REG_CTRL  = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_DONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FILL,
        ST_FINISH
    } fill_state_e;

    function automatic logic [8:0] clip_end(input logic [8:0] sum, input logic [8:0] limit);
        return (sum > limit) ? limit : sum;
    endfunction

endpackage

// File: rtl/fb_rect_walker.sv
// Pixel walker for the rectangle fill: holds the working rectangle, clips it
// to the framebuffer and steps x/y/row_base/address one pixel per advance.
module fb_rect_walker
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
    parameter int ADDR_W    = 15
) (
    input  logic              I_wb_clk,
    input  logic              I_wb_rst,
    input  logic              I_load,
    input  logic [7:0]        I_x0,
    input  logic [7:0]        I_y0,
    input  logic [7:0]        I_w,
    input  logic [7:0]        I_h,
    input  logic              I_setup,
    input  logic              I_advance,
    output logic              O_empty,
    output logic              O_last,
    output logic [ADDR_W-1:0] O_adr
);

    localparam logic [8:0]        FBW9     = 9'(FB_WIDTH);
    localparam logic [8:0]        FBH9     = 9'(FB_HEIGHT);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

    logic [7:0]        x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic [8:0]        x_end_q, x_end_d, y_end_q, y_end_d;
    logic [8:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, adr_q, adr_d;
    logic [ADDR_W-1:0] x0_a, y0_a, first_row;
    logic              row_end;

    assign x0_a = ADDR_W'(x0_q);
    assign y0_a = ADDR_W'(y0_q);
    // Y0*160 as a shift-add; any other width falls back to a constant multiply.
    assign first_row = (FB_WIDTH == 160) ? (y0_a << 7) + (y0_a << 5) : y0_a * ROW_STEP;

    assign row_end = (x_q + 9'd1) == x_end_q;
    assign O_last  = row_end && ((y_q + 9'd1) == y_end_q);
    assign O_empty = (w_q == 8'd0) || (h_q == 8'd0) ||
                     ({1'b0, x0_q} >= FBW9) || ({1'b0, y0_q} >= FBH9);
    assign O_adr   = adr_q;

    always_comb begin
        // NOTE: every _d defaults to its _q before any branch, so no path can infer a latch.
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        adr_d      = adr_q;
        if (I_load) begin
            x0_d = I_x0;
            y0_d = I_y0;
            w_d  = I_w;
            h_d  = I_h;
        end
        if (I_setup) begin
            x_end_d    = clip_end({1'b0, x0_q} + {1'b0, w_q}, FBW9);
            y_end_d    = clip_end({1'b0, y0_q} + {1'b0, h_q}, FBH9);
            x_d        = {1'b0, x0_q};
            y_d        = {1'b0, y0_q};
            row_base_d = first_row;
            adr_d      = first_row + x0_a;
        end else if (I_advance) begin
            if (row_end) begin
                x_d        = {1'b0, x0_q};
                y_d        = y_q + 9'd1;
                row_base_d = row_base_q + ROW_STEP;
                adr_d      = row_base_q + ROW_STEP + x0_a;
            end else begin
                x_d   = x_q + 9'd1;
                adr_d = adr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge I_wb_clk or posedge I_wb_rst) begin
        if (I_wb_rst) begin
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            adr_q      <= '0;
        end else begin
            // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            adr_q      <= adr_d;
        end
    end

endmodule

// File: rtl/wb_fb_rect_fill.sv
// Wishbone rectangle-fill engine: a register slave for X0/Y0/W/H/COLOR/CTRL and
// a master that writes one RGB332 pixel per ack into the framebuffer.
module wb_fb_rect_fill
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = fb_pkg::FB_HEIGHT,
    parameter int ADDR_W    = 15
) (
    input  logic              I_wb_clk,
    input  logic              I_wb_rst,
    input  logic [2:0]        I_s_adr,
    input  logic [7:0]        I_s_dat,
    input  logic              I_s_we,
    input  logic              I_s_stb,
    input  logic              I_s_cyc,
    output logic              O_s_ack,
    output logic [7:0]        O_s_dat,
    output logic [ADDR_W-1:0] O_m_adr,
    output logic [7:0]        O_m_dat,
    output logic              O_m_we,
    output logic              O_m_stb,
    output logic              O_m_cyc,
    input  logic              I_m_ack,
    output logic              O_busy,
    output logic              O_done
);

    logic [7:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d, color_q, color_d;
    logic        done_flag_q, done_flag_d;
    logic        s_ack_q, s_ack_d;
    logic [7:0]  s_dat_q, s_dat_d;
    logic [7:0]  rdata;
    logic        req, wr, ctrl_wr, start;

    fill_state_e state_q;
    logic        busy_q, done_q, m_cyc_q, m_stb_q, m_we_q;
    logic [7:0]  m_dat_q, work_color_q;
    logic        walk_empty, walk_last;

    // A request is only taken in the cycle before its ack, so a held strobe never writes twice.
    assign req     = I_s_stb & I_s_cyc & ~s_ack_q;
    assign wr      = req & I_s_we;
    assign ctrl_wr = wr && (I_s_adr == REG_CTRL);
    assign start   = ctrl_wr && I_s_dat[CTRL_START] && (state_q == ST_IDLE);

    always_comb begin
        rdata = '0;
        case (I_s_adr)
            REG_X0:    rdata = x0_q;
            REG_Y0:    rdata = y0_q;
            REG_W:     rdata = w_q;
            REG_H:     rdata = h_q;
            REG_COLOR: rdata = color_q;
            REG_CTRL: begin
                rdata[CTRL_BUSY] = busy_q;
                rdata[CTRL_DONE] = done_flag_q;
            end
            default:   rdata = '0;
        endcase
    end

    always_comb begin
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        done_flag_d = done_flag_q;
        s_ack_d     = req;
        s_dat_d     = req ? rdata : s_dat_q;
        if (wr) begin
            case (I_s_adr)
                REG_X0:    x0_d    = I_s_dat;
                REG_Y0:    y0_d    = I_s_dat;
                REG_W:     w_d     = I_s_dat;
                REG_H:     h_d     = I_s_dat;
                REG_COLOR: color_d = I_s_dat;
                default:   ;
            endcase
        end
        if (ctrl_wr && I_s_dat[CTRL_CLEAR]) done_flag_d = 1'b0;
        // Completion overrides a clear landing in the same cycle.
        if (state_q == ST_FINISH) done_flag_d = 1'b1;
    end

    always_ff @(posedge I_wb_clk or posedge I_wb_rst) begin
        if (I_wb_rst) begin
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            done_flag_q <= 1'b0;
            s_ack_q     <= 1'b0;
            s_dat_q     <= '0;
        end else begin
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            done_flag_q <= done_flag_d;
            s_ack_q     <= s_ack_d;
            s_dat_q     <= s_dat_d;
        end
    end

    always_ff @(posedge I_wb_clk or posedge I_wb_rst) begin
        if (I_wb_rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            m_cyc_q      <= 1'b0;
            m_stb_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_dat_q      <= '0;
            work_color_q <= '0;
        end else begin
            done_q <= (state_q == ST_FINISH);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_SETUP;
                        busy_q       <= 1'b1;
                        work_color_q <= color_q;
                    end
                end
                ST_SETUP: begin
                    if (walk_empty) begin
                        state_q <= ST_FINISH;
                    end else begin
                        state_q <= ST_FILL;
                        m_cyc_q <= 1'b1;
                        m_stb_q <= 1'b1;
                        m_we_q  <= 1'b1;
                        m_dat_q <= work_color_q;
                    end
                end
                ST_FILL: begin
                    if (I_m_ack && walk_last) begin
                        state_q <= ST_FINISH;
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        m_we_q  <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fb_rect_walker #(
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT),
        .ADDR_W   (ADDR_W)
    ) u_walker (
        .I_wb_clk (I_wb_clk),
        .I_wb_rst (I_wb_rst),
        .I_load   (start),
        .I_x0     (x0_q),
        .I_y0     (y0_q),
        .I_w      (w_q),
        .I_h      (h_q),
        .I_setup  (state_q == ST_SETUP),
        .I_advance((state_q == ST_FILL) && I_m_ack && !walk_last),
        .O_empty  (walk_empty),
        .O_last   (walk_last),
        .O_adr    (O_m_adr)
    );

    assign O_s_ack = s_ack_q;
    assign O_s_dat = s_dat_q;
    assign O_m_dat = m_dat_q;
    assign O_m_we  = m_we_q;
    assign O_m_stb = m_stb_q;
    assign O_m_cyc = m_cyc_q;
    assign O_busy  = busy_q;
    assign O_done  = done_q;

endmodule

// File: tb/tb_wb_fb_rect_fill.sv
// Self-checking bench for wb_fb_rect_fill: a framebuffer responder with
// configurable random ack delay, and a nested-loop model of the clipped fill.
module tb_wb_fb_rect_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  s_adr = '0;
    logic [7:0]  s_dat = '0;
    logic        s_we = 1'b0, s_stb = 1'b0, s_cyc = 1'b0;
    logic        s_ack;
    logic [7:0]  s_rdat;
    logic [14:0] m_adr;
    logic [7:0]  m_dat;
    logic        m_we, m_stb, m_cyc;
    logic        m_ack = 1'b0;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int cyc_cnt  = 0;
    int proto_err = 0;
    int ack_max  = 0;
    int adr_q[$];
    int dat_q[$];
    int exp_q[$];

    wb_fb_rect_fill dut (
        .I_wb_clk(clk),
        .I_wb_rst(rst),
        .I_s_adr (s_adr),
        .I_s_dat (s_dat),
        .I_s_we  (s_we),
        .I_s_stb (s_stb),
        .I_s_cyc (s_cyc),
        .O_s_ack (s_ack),
        .O_s_dat (s_rdat),
        .O_m_adr (m_adr),
        .O_m_dat (m_dat),
        .O_m_we  (m_we),
        .O_m_stb (m_stb),
        .O_m_cyc (m_cyc),
        .I_m_ack (m_ack),
        .O_busy  (busy),
        .O_done  (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_cyc === 1'b1) cyc_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // Framebuffer model: acks each strobed pixel after 0..ack_max idle cycles.
    bit pending = 1'b0;
    int wait_cnt = 0;
    int pend_adr = 0;
    always @(negedge clk) begin
        if (rst) begin
            m_ack   = 1'b0;
            pending = 1'b0;
        end else if (m_ack) begin
            m_ack = 1'b0;
        end else if (m_cyc === 1'b1 && m_stb === 1'b1) begin
            if (m_we !== 1'b1) proto_err++;
            if (!pending) begin
                pending  = 1'b1;
                pend_adr = int'(m_adr);
                wait_cnt = (ack_max == 0) ? 0 : int'($urandom_range(ack_max, 0));
            end else if (int'(m_adr) != pend_adr) begin
                proto_err++;
            end
            if (wait_cnt == 0) begin
                m_ack   = 1'b1;
                pending = 1'b0;
                adr_q.push_back(int'(m_adr));
                dat_q.push_back(int'(m_dat));
            end else begin
                wait_cnt--;
            end
        end else if (pending) begin
            proto_err++;
            pending = 1'b0;
        end
    end

    task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        s_adr = a; s_dat = d; s_we = 1'b1; s_stb = 1'b1; s_cyc = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL slave_write_ack reg=%0d got=%b want=1", a, s_ack);
        end
        @(negedge clk);
        s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        s_adr = a; s_we = 1'b0; s_stb = 1'b1; s_cyc = 1'b1;
        @(posedge clk);
        #1;
        d = s_rdat;
        @(negedge clk);
        s_stb = 1'b0; s_cyc = 1'b0;
    endtask

    task automatic program_rect(input int x0, input int y0, input int w, input int h, input int color);
        wb_write(3'd0, 8'(x0));
        wb_write(3'd1, 8'(y0));
        wb_write(3'd2, 8'(w));
        wb_write(3'd3, 8'(h));
        wb_write(3'd4, 8'(color));
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done_timeout got=no O_done within %0d cycles want=O_done", name, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    // Expected writes: every clipped pixel, row by row, at y*160+x.
    task automatic build_model(input int x0, input int y0, input int w, input int h);
        int xe = (x0 + w > 160) ? 160 : x0 + w;
        int ye = (y0 + h > 120) ? 120 : y0 + h;
        exp_q.delete();
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                exp_q.push_back(y * 160 + x);
    endtask

    function automatic int seq_errors(input int color);
        int e = (adr_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < adr_q.size() && i < exp_q.size(); i++)
            if (adr_q[i] != exp_q[i] || dat_q[i] != color) e++;
        return e;
    endfunction

    task automatic test_reset();
        logic [7:0] rd;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({s_ack, s_rdat, m_adr, m_dat, m_we, m_stb, m_cyc, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {s_ack, s_rdat, m_adr, m_dat, m_we, m_stb, m_cyc, busy, done});
        end
        rst = 1'b0;
        wb_write(3'd6, 8'hFF);
        wb_write(3'd7, 8'h5A);
        for (int r = 0; r < 8; r++) begin
            wb_read(3'(r), rd);
            n_checks++;
            if (rd !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg%0d got=%h want=00", r, rd);
            end
        end
    endtask

    task automatic test_full_fill();
        int d0;
        logic [7:0] rd;
        ack_max = 0; proto_err = 0;
        program_rect(0, 0, 160, 120, 8'hE0);
        adr_q.delete(); dat_q.delete();
        d0 = done_cnt;
        wb_write(3'd5, 8'h03);
        wait_done(45000, "full");
        build_model(0, 0, 160, 120);
        n_checks++;
        if (adr_q.size() != 19200) begin
            n_fail++;
            $display("FAIL full_count got=%0d want=19200", adr_q.size());
        end
        n_checks++;
        if (seq_errors(8'hE0) != 0) begin
            n_fail++;
            $display("FAIL full_sequence got=%0d bad writes want=0", seq_errors(8'hE0));
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL full_done_pulses got=%0d want=1", done_cnt - d0);
        end
        wb_read(3'd5, rd);
        n_checks++;
        if (rd !== 8'h02) begin
            n_fail++;
            $display("FAIL full_ctrl_read got=%h want=02", rd);
        end
        n_checks++;
        if (proto_err != 0) begin
            n_fail++;
            $display("FAIL full_protocol got=%0d errors want=0", proto_err);
        end
    endtask

    task automatic test_clipped();
        ack_max = 0; proto_err = 0;
        program_rect(150, 115, 20, 10, 8'h1C);
        adr_q.delete(); dat_q.delete();
        wb_write(3'd5, 8'h03);
        wait_done(2000, "clip");
        build_model(150, 115, 20, 10);
        n_checks++;
        if (adr_q.size() != 50) begin
            n_fail++;
            $display("FAIL clip_count got=%0d want=50", adr_q.size());
        end else begin
            n_checks++;
            if (adr_q[0] != 18550 || adr_q[49] != 19199 || adr_q[10] - adr_q[0] != 160) begin
                n_fail++;
                $display("FAIL clip_bounds got=first %0d last %0d step %0d want=18550 19199 160",
                         adr_q[0], adr_q[49], adr_q[10] - adr_q[0]);
            end
        end
        n_checks++;
        if (seq_errors(8'h1C) != 0) begin
            n_fail++;
            $display("FAIL clip_sequence got=%0d bad writes want=0", seq_errors(8'h1C));
        end
    endtask

    task automatic test_degenerate();
        int cfg[4][4] = '{'{10, 10, 0, 5}, '{200, 10, 5, 5}, '{0, 0, 5, 0}, '{5, 130, 5, 5}};
        for (int k = 0; k < 4; k++) begin
            int c0, d0, first;
            program_rect(cfg[k][0], cfg[k][1], cfg[k][2], cfg[k][3], 8'hFF);
            adr_q.delete(); dat_q.delete();
            c0 = cyc_cnt; d0 = done_cnt; first = -1;
            wb_write(3'd5, 8'h01);
            // Cycle 1 follows the start edge; count which cycle O_done shows up in.
            for (int n = 1; n <= 6; n++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1 && first < 0) first = n + 1;
            end
            n_checks++;
            if (first != 3) begin
                n_fail++;
                $display("FAIL degen%0d_done_cycle got=%0d want=3", k, first);
            end
            n_checks++;
            if (cyc_cnt != c0 || adr_q.size() != 0 || done_cnt - d0 != 1) begin
                n_fail++;
                $display("FAIL degen%0d_activity got=cyc %0d writes %0d done %0d want=0 0 1",
                         k, cyc_cnt - c0, adr_q.size(), done_cnt - d0);
            end
        end
    endtask

    task automatic test_random_ack();
        int exp_lit[6] = '{3210, 3211, 3212, 3370, 3371, 3372};
        int e = 0;
        ack_max = 5; proto_err = 0;
        program_rect(10, 20, 3, 2, 8'h5A);
        adr_q.delete(); dat_q.delete();
        wb_write(3'd5, 8'h03);
        @(posedge clk);
        #1;
        n_checks++;
        if (m_stb !== 1'b1 || m_adr !== 15'd3210) begin
            n_fail++;
            $display("FAIL rack_first_strobe got=stb %b adr %0d want=stb 1 adr 3210", m_stb, m_adr);
        end
        wait_done(500, "rack");
        if (adr_q.size() != 6) e++;
        for (int i = 0; i < 6 && i < adr_q.size(); i++)
            if (adr_q[i] != exp_lit[i] || dat_q[i] != 8'h5A) e++;
        n_checks++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL rack_sequence got=%0d bad writes (count %0d) want=0", e, adr_q.size());
        end
        n_checks++;
        if (proto_err != 0) begin
            n_fail++;
            $display("FAIL rack_stb_held got=%0d errors want=0", proto_err);
        end
    endtask

    task automatic test_random_rects();
        for (int k = 0; k < 8; k++) begin
            int x0 = int'($urandom_range(170, 0));
            int y0 = int'($urandom_range(125, 0));
            int w  = int'($urandom_range(24, 0));
            int h  = int'($urandom_range(6, 0));
            int c  = int'($urandom_range(255, 0));
            int d0;
            ack_max = int'($urandom_range(3, 0)); proto_err = 0;
            program_rect(x0, y0, w, h, c);
            adr_q.delete(); dat_q.delete();
            d0 = done_cnt;
            wb_write(3'd5, 8'h03);
            wait_done(1500, "rand");
            build_model(x0, y0, w, h);
            n_checks++;
            if (seq_errors(c) != 0 || proto_err != 0 || done_cnt - d0 != 1) begin
                n_fail++;
                $display("FAIL rand%0d rect=(%0d,%0d,%0d,%0d) got=bad %0d proto %0d done %0d want=0 0 1",
                         k, x0, y0, w, h, seq_errors(c), proto_err, done_cnt - d0);
            end
        end
    endtask

    task automatic test_busy_start();
        int d0, c_end;
        logic [7:0] rd;
        ack_max = 1; proto_err = 0;
        program_rect(5, 3, 40, 4, 8'hA5);
        adr_q.delete(); dat_q.delete();
        d0 = done_cnt;
        wb_write(3'd5, 8'h03);
        repeat (20) @(negedge clk);
        wb_write(3'd4, 8'h3C);
        wb_write(3'd0, 8'h00);
        wb_write(3'd5, 8'h01);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_midfill got=%b want=1", busy);
        end
        wait_done(2000, "busy");
        c_end = cyc_cnt;
        repeat (20) @(negedge clk);
        build_model(5, 3, 40, 4);
        n_checks++;
        if (seq_errors(8'hA5) != 0) begin
            n_fail++;
            $display("FAIL busy_sequence got=%0d bad writes (count %0d) want=0", seq_errors(8'hA5), adr_q.size());
        end
        n_checks++;
        if (done_cnt - d0 != 1 || cyc_cnt != c_end || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_second_start got=done %0d extra_cyc %0d busy %b want=1 0 0",
                     done_cnt - d0, cyc_cnt - c_end, busy);
        end
        wb_read(3'd4, rd);
        n_checks++;
        if (rd !== 8'h3C) begin
            n_fail++;
            $display("FAIL busy_color_reg got=%h want=3c", rd);
        end
    endtask

    task automatic test_reset_mid_fill();
        int d0;
        ack_max = 0; proto_err = 0;
        program_rect(0, 10, 20, 10, 8'h77);
        adr_q.delete(); dat_q.delete();
        wb_write(3'd5, 8'h03);
        repeat (30) @(negedge clk);
        d0 = done_cnt;
        n_checks++;
        if (m_cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_precondition got=cyc %b want=1", m_cyc);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({m_cyc, m_stb, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_async got=cyc/stb/busy %b want=000", {m_cyc, m_stb, busy});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL rstmid_no_done got=%0d pulses want=0", done_cnt - d0);
        end
        program_rect(3, 100, 15, 8, 8'h42);
        adr_q.delete(); dat_q.delete();
        d0 = done_cnt; proto_err = 0;
        wb_write(3'd5, 8'h01);
        wait_done(1000, "rstmid");
        build_model(3, 100, 15, 8);
        n_checks++;
        if (seq_errors(8'h42) != 0 || done_cnt - d0 != 1 || proto_err != 0) begin
            n_fail++;
            $display("FAIL rstmid_refill got=bad %0d done %0d proto %0d want=0 1 0",
                     seq_errors(8'h42), done_cnt - d0, proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_full_fill();
        test_clipped();
        test_degenerate();
        test_random_ack();
        test_random_rects();
        test_busy_start();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_fb_rect_fill.md
Name: wb_fb_rect_fill

Overview:
- Wishbone rectangle-fill engine that sits directly upstream of the 160x120 RGB332 framebuffer write port.
- The CPU programs a rectangle and a colour through a small register-slave port, then writes a start command.
- The block issues one Wishbone master write per pixel into the framebuffer, at address y*160+x.
- Runs entirely in the I_wb_clk domain. Offloads bulk clears and fills from the CPU.

Parameters:
- FB_WIDTH, 160, framebuffer width in pixels
- FB_HEIGHT, 120, framebuffer height in pixels
- ADDR_W, 15, master address width (must cover FB_WIDTH*FB_HEIGHT-1)

Ports:
- I_wb_clk  in  1  clock (sole clock)
- I_wb_rst  in  1  reset; asynchronous, active-high
- I_s_adr  in  3  slave register index
- I_s_dat  in  8  slave write data
- I_s_we  in  1  slave write enable
- I_s_stb  in  1  slave strobe
- I_s_cyc  in  1  slave cycle
- O_s_ack  out  1  slave acknowledge
- O_s_dat  out  8  slave read data
- O_m_adr  out  ADDR_W  master pixel address
- O_m_dat  out  8  master write data (RGB332 colour)
- O_m_we  out  1  master write enable (high whenever O_m_cyc is high)
- O_m_stb  out  1  master strobe
- O_m_cyc  out  1  master cycle
- I_m_ack  in  1  master acknowledge from framebuffer
- O_busy  out  1  fill in progress
- O_done  out  1  one-cycle pulse when a fill completes

Behaviour:
- Reset values: every output is 0; all registers are 0; state = IDLE.
- A reset asserted mid-fill drops O_m_cyc/O_m_stb immediately. No completion pulse is produced.
- Register map (I_s_adr):
  - 0 = X0
  - 1 = Y0
  - 2 = W
  - 3 = H
  - 4 = COLOR
  - 5 = CTRL
  - 6, 7 read 0; writes to 6, 7 are ignored.
- CTRL write: bit0=1 requests start; bit1=1 clears the sticky DONE flag.
- CTRL read: {6'b0, DONE, BUSY}.
- Slave handshake: O_s_ack <= stb & cyc & ~O_s_ack. This is a single-cycle ack, one cycle after the request.
  - O_s_dat is registered alongside the ack.
  - Writes take effect on the request cycle's clock edge.
- Writes to X0/Y0/W/H/COLOR while BUSY are accepted, but do not affect the fill in progress.
- A start request while BUSY is ignored.
- FSM states: IDLE, SETUP, FILL, FINISH.
  - IDLE: a start request latches the working copies of the registers and moves to SETUP on the next edge.
  - SETUP (one cycle): clips the rectangle.
    - x_end = min(X0+W, FB_WIDTH); y_end = min(Y0+H, FB_HEIGHT). Use 9-bit sums so there is no wrap.
    - If W==0, H==0, X0>=FB_WIDTH or Y0>=FB_HEIGHT: go directly to FINISH with no master writes.
    - Otherwise: row_base = Y0*160 computed as (Y0<<7)+(Y0<<5); x=X0; y=Y0; go to FILL.
  - FILL:
    - Outputs: O_m_cyc=O_m_stb=O_m_we=1, O_m_adr=row_base+x, O_m_dat=COLOR.
    - On I_m_ack, advance the pixel: x+1.
    - Row end: at x+1==x_end, set x=X0, y+1, row_base+=FB_WIDTH. No multiplier is used in the loop.
    - Strobe stays high across consecutive pixels (pipelined-by-ack). Throughput is 1 pixel per ack.
    - The ack of the last pixel (x==x_end-1, y==y_end-1) deasserts cyc/stb on the next edge and moves to FINISH.
  - FINISH (one cycle): O_done=1; sets sticky DONE; returns to IDLE.
- O_busy = state != IDLE.
- Start-to-first-strobe latency: the CTRL write edge enters SETUP, and stb is high in the cycle after SETUP. That is 2 cycles after the request edge.
- I_m_ack is ignored outside FILL.
- If the DONE-clear and FINISH occur in the same cycle, the set wins.

Decomposition:
- Shared package fb_pkg holds: FB_WIDTH, FB_HEIGHT, FB_SIZE, the register index constants (REG_X0..REG_CTRL), and the CTRL bit positions. The framebuffer module uses the same package.
- One natural sub-module, fb_rect_walker: the x/y/row_base counter with the clipping logic, driven by advance/load strobes from the FSM.
- Slave decode and the FSM stay in the top level.

Test Plan:
- Fill X0=0,Y0=0,W=160,H=120,COLOR=0xE0 against a framebuffer model acking one cycle after stb:
  - exactly 19200 writes, addresses 0..19199 in order, all data 0xE0;
  - O_done pulses once; CTRL reads 0x02.
- X0=150,Y0=115,W=20,H=10 (clipped to 10x5):
  - 50 writes; first address 18550, row step 160, last address 19199.
- W=0 or X0=200:
  - no O_m_cyc activity; O_done exactly 3 cycles after the start write edge.
- Framebuffer model with random 0-5 cycle ack delay, X0=10,Y0=20,W=3,H=2:
  - write sequence 3210,3211,3212,3370,3371,3372 with no duplicates or skips;
  - stb held until each ack.
- Start write while BUSY, plus a COLOR change mid-fill:
  - the fill in progress keeps the original colour and count;
  - the second start is ignored.
- I_wb_rst asserted mid-fill:
  - cyc/stb/busy go to 0 asynchronously; no O_done;
  - a subsequent start runs a full correct fill.
